// File: rtl/csr_int_ctrl_pkg.sv
// rtl/csr_int_ctrl_pkg.sv - IS bit positions, ECFG/ESTAT field offsets and writable masks
package csr_int_ctrl_pkg;

  localparam int IS_SWI0 = 0;
  localparam int IS_HWI0 = 2;
  localparam int IS_TI   = 11;
  localparam int IS_IPI  = 12;

  localparam int ECFG_LIE_OFF    = 0;
  localparam int ECFG_VS_OFF     = 16;
  localparam int ESTAT_IS_OFF    = 0;
  localparam int ESTAT_ECODE_OFF = 16;
  localparam int ESTAT_ESUB_OFF  = 22;

  localparam logic [31:0] ECFG_LIE_WMASK = 32'h0000_1BFF;
  localparam logic [31:0] ECFG_VS_WMASK  = 32'h0000_0007 << ECFG_VS_OFF;
  localparam logic [31:0] ESTAT_SW_WMASK = 32'h0000_0003 << ESTAT_IS_OFF;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [31:0] wmask,
                                               input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old_val & ~m) | (wdata & m);
  endfunction

  // Later indices overwrite earlier ones, so bit 12 wins.
  function automatic logic [3:0] highest_idx(input logic [12:0] p);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 13; i++) begin
      if (p[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/csr_int_ctrl_int_sync.sv
// rtl/csr_int_ctrl_int_sync.sv - flop chain synchronizer for one hardware interrupt line
module int_sync
  import csr_int_ctrl_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/csr_int_ctrl.sv
// rtl/csr_int_ctrl.sv - ECFG/ESTAT CSRs with interrupt pending, priority and request
module csr_int_ctrl
  import csr_int_ctrl_pkg::*;
#(
  parameter int NUM_HWI     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VS_EN       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ecfg_we,
  input  logic               estat_we,
  input  logic [31:0]        wdata,
  input  logic [31:0]        wmask,
  input  logic               ticlr_we,
  input  logic [NUM_HWI-1:0] hwi,
  input  logic               ipi,
  input  logic               timer_fire,
  input  logic               crmd_ie,
  input  logic               exc_commit,
  input  logic [5:0]         exc_ecode,
  input  logic [8:0]         exc_esubcode,
  output logic [31:0]        ecfg,
  output logic [31:0]        estat,
  output logic               int_req,
  output logic [3:0]         int_idx
);

  localparam logic [31:0] ECFG_WR = (VS_EN != 0) ? (ECFG_LIE_WMASK | ECFG_VS_WMASK) : ECFG_LIE_WMASK;

  logic [31:0] r_ecfg;
  logic [31:0] r_estat_sw;
  logic        r_ti;
  logic        r_ipi;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esub;
  logic        r_int_req;
  logic [3:0]  r_int_idx;

  logic [7:0]  w_hwi_is;
  logic [31:0] w_estat;
  logic [12:0] w_pend;

  for (genvar k = 0; k < 8; k++) begin : g_hwi
    if (k < NUM_HWI) begin : g_on
      int_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (hwi[k]),
        .o_q   (w_hwi_is[k])
      );
    end else begin : g_off
      assign w_hwi_is[k] = 1'b0;
    end
  end

  // r_estat_sw only ever holds the software IS bits; every other field is live hardware state.
  always_comb begin
    w_estat                            = r_estat_sw;
    w_estat[IS_HWI0 +: 8]              = w_hwi_is;
    w_estat[IS_TI]                     = r_ti;
    w_estat[IS_IPI]                    = r_ipi;
    w_estat[ESTAT_ECODE_OFF +: 6]      = r_ecode;
    w_estat[ESTAT_ESUB_OFF +: 9]       = r_esub;
  end

  assign w_pend = w_estat[IS_SWI0 +: 13] & r_ecfg[ECFG_LIE_OFF +: 13];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ecfg     <= '0;
      r_estat_sw <= '0;
      r_ti       <= 1'b0;
      r_ipi      <= 1'b0;
      r_ecode    <= '0;
      r_esub     <= '0;
      r_int_req  <= 1'b0;
      r_int_idx  <= '0;
    end else begin
      if (ecfg_we) r_ecfg <= masked_write(r_ecfg, wdata, wmask, ECFG_WR);
      if (estat_we) r_estat_sw <= masked_write(r_estat_sw, wdata, wmask, ESTAT_SW_WMASK);
      // A timer expiry coinciding with a clear must not be lost.
      if (timer_fire) r_ti <= 1'b1;
      else if (ticlr_we && wdata[0]) r_ti <= 1'b0;
      r_ipi <= ipi;
      if (exc_commit) begin
        r_ecode <= exc_ecode;
        r_esub  <= exc_esubcode;
      end
      r_int_req <= (|w_pend) & crmd_ie;
      r_int_idx <= highest_idx(w_pend);
    end
  end

  assign ecfg    = r_ecfg;
  assign estat   = w_estat;
  assign int_req = r_int_req;
  assign int_idx = r_int_idx;

endmodule

// File: tb/tb_csr_int_ctrl.sv
// tb/tb_csr_int_ctrl.sv - scoreboard bench for csr_int_ctrl
module tb_csr_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecfg_we, estat_we, ticlr_we;
  logic [31:0] wdata, wmask;
  logic [7:0]  hwi;
  logic        ipi, timer_fire, crmd_ie, exc_commit;
  logic [5:0]  exc_ecode;
  logic [8:0]  exc_esubcode;
  logic [31:0] ecfg, estat;
  logic        int_req;
  logic [3:0]  int_idx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
    int          due;
  } exp_t;
  exp_t sb[$];

  localparam int S_ECFG = 0, S_ESTAT = 1, S_REQ = 2, S_IDX = 3;

  csr_int_ctrl #(.NUM_HWI(8), .SYNC_STAGES(2), .VS_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ecfg_we      (ecfg_we),
    .estat_we     (estat_we),
    .wdata        (wdata),
    .wmask        (wmask),
    .ticlr_we     (ticlr_we),
    .hwi          (hwi),
    .ipi          (ipi),
    .timer_fire   (timer_fire),
    .crmd_ie      (crmd_ie),
    .exc_commit   (exc_commit),
    .exc_ecode    (exc_ecode),
    .exc_esubcode (exc_esubcode),
    .ecfg         (ecfg),
    .estat        (estat),
    .int_req      (int_req),
    .int_idx      (int_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_ECFG:  return ecfg;
      S_ESTAT: return estat;
      S_REQ:   return {31'b0, int_req};
      default: return {28'b0, int_idx};
    endcase
  endfunction

  task automatic expect_at(input string tag, input int sel, input logic [31:0] val, input int lat);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, sample(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; ecfg_we = 0; estat_we = 0; ticlr_we = 0; wdata = '0; wmask = '0;
    hwi = '0; ipi = 0; timer_fire = 0; crmd_ie = 0; exc_commit = 0;
    exc_ecode = '0; exc_esubcode = '0;

    expect_at("rst_ecfg", S_ECFG, 32'h0, 1);
    expect_at("rst_estat", S_ESTAT, 32'h0, 1);
    expect_at("rst_req", S_REQ, 32'h0, 1);
    expect_at("rst_idx", S_IDX, 32'h0, 1);
    tick();
    rst = 1'b0;

    ecfg_we = 1; wdata = 32'hFFFF_FFFF; wmask = 32'hFFFF_FFFF;
    expect_at("ecfg_all_ones", S_ECFG, 32'h0007_1BFF, 1);
    tick();
    wdata = 32'h0; wmask = 32'h0000_0F00;
    expect_at("ecfg_masked_clr", S_ECFG, 32'h0007_10FF, 1);
    tick();
    wdata = 32'hFFFF_FFFF; wmask = 32'hFFFF_FFFF;
    tick();
    wdata = 32'h0000_0400; wmask = 32'h0000_0400;
    expect_at("ecfg_bit10", S_ECFG, 32'h0007_1BFF, 1);
    tick();
    ecfg_we = 0;

    crmd_ie = 1; estat_we = 1; wdata = 32'h3; wmask = 32'h1;
    expect_at("swi_estat", S_ESTAT, 32'h1, 1);
    expect_at("swi_req_lat", S_REQ, 32'h0, 1);
    expect_at("swi_req", S_REQ, 32'h1, 2);
    expect_at("swi_idx", S_IDX, 32'h0, 2);
    tick();
    estat_we = 0;
    tick();

    estat_we = 1; wdata = 32'hFFFF_FFFC; wmask = 32'hFFFF_FFFF;
    expect_at("estat_ro_ignored", S_ESTAT, 32'h0, 1);
    expect_at("swi_req_clr", S_REQ, 32'h0, 2);
    tick();
    estat_we = 0;
    tick();

    hwi[3] = 1'b1;
    expect_at("hwi_rise_e1", S_ESTAT, 32'h0, 1);
    expect_at("hwi_rise_e2", S_ESTAT, 32'h20, 2);
    expect_at("hwi_req_e2", S_REQ, 32'h0, 2);
    expect_at("hwi_req_e3", S_REQ, 32'h1, 3);
    expect_at("hwi_idx", S_IDX, 32'h5, 3);
    ticks(3);
    hwi[3] = 1'b0;
    expect_at("hwi_fall_e1", S_ESTAT, 32'h20, 1);
    expect_at("hwi_fall_e2", S_ESTAT, 32'h0, 2);
    expect_at("hwi_fall_req_e2", S_REQ, 32'h1, 2);
    expect_at("hwi_fall_req_e3", S_REQ, 32'h0, 3);
    ticks(3);

    timer_fire = 1; ticlr_we = 1; wdata = 32'h1;
    expect_at("ti_fire_and_clr", S_ESTAT, 32'h800, 1);
    expect_at("ti_req", S_REQ, 32'h1, 2);
    expect_at("ti_idx", S_IDX, 32'hB, 2);
    tick();
    timer_fire = 0;
    expect_at("ti_clr", S_ESTAT, 32'h0, 1);
    tick();
    ticlr_we = 0; wdata = 32'h0;
    ticks(2);

    timer_fire = 1; ipi = 1; hwi[0] = 1'b1;
    expect_at("multi_estat", S_ESTAT, 32'h1804, 2);
    expect_at("multi_idx", S_IDX, 32'hC, 3);
    expect_at("multi_req", S_REQ, 32'h1, 3);
    tick();
    timer_fire = 0;
    ticks(2);
    crmd_ie = 0;
    expect_at("ie_off_req", S_REQ, 32'h0, 1);
    expect_at("ie_off_idx", S_IDX, 32'hC, 1);
    tick();

    rst = 1; exc_commit = 1; exc_ecode = 6'h0B; exc_esubcode = 9'h1;
    estat_we = 1; ecfg_we = 1; wdata = 32'h3; wmask = 32'hFFFF_FFFF; timer_fire = 1;
    ipi = 0; hwi = '0;
    expect_at("rstdom_estat", S_ESTAT, 32'h0, 1);
    expect_at("rstdom_ecfg", S_ECFG, 32'h0, 1);
    expect_at("rstdom_req", S_REQ, 32'h0, 1);
    expect_at("rstdom_idx", S_IDX, 32'h0, 1);
    tick();
    rst = 0; ecfg_we = 0; timer_fire = 0; wdata = 32'h1; wmask = 32'h3;
    expect_at("exc_estat", S_ESTAT, 32'h004B_0001, 1);
    tick();
    exc_commit = 0; estat_we = 0;
    exc_ecode = 6'h3F; exc_esubcode = 9'h1FF;
    expect_at("exc_hold", S_ESTAT, 32'h004B_0001, 1);
    tick();

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) check("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
